// File: rtl/ula_ctrl_pkg.sv
// Shared state encoding, bus-select codes and per-state output decode for the ULA sequencer.
// Pure declarations, no logic or latency of its own.
// No flow control here; consumers apply their own gating.
package ula_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        STORE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] SEL_A   = 2'd0;
    localparam logic [1:0] SEL_B   = 2'd1;
    localparam logic [1:0] SEL_RES = 2'd2;

    typedef struct packed {
        logic       en_a;
        logic       en_b;
        logic       en_res;
        logic [1:0] bus_sel;
        logic       busy;
        logic       done;
    } dec_t;

    function automatic dec_t decode(input state_t s);
        dec_t d;
        d = '0;
        case (s)
            LOAD_A: begin d.en_a = 1'b1; d.bus_sel = SEL_A; d.busy = 1'b1; end
            LOAD_B: begin d.en_b = 1'b1; d.bus_sel = SEL_B; d.busy = 1'b1; end
            EXEC:   begin d.bus_sel = SEL_RES; d.busy = 1'b1; end
            STORE:  begin d.en_res = 1'b1; d.bus_sel = SEL_RES; d.busy = 1'b1; end
            DONE:   begin d.done = 1'b1; d.bus_sel = SEL_RES; d.busy = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ula_wait_cnt.sv
// 4-bit down-counter with load, decrement and zero flag for the EXEC dwell.
// Load/decrement take effect on the next edge; zero is combinational from the count.
// No backpressure; decrement saturates at zero.
module ula_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/ula_seq_ctrl.sv
// Sequences A/B/RES register loads over a shared source bus and counts completed operations.
// One operation takes EXEC_CYCLES+5 cycles from start sample to done pulse (IDLE included).
// start is ignored while busy; abort returns to IDLE and masks enables in the same cycle.
module ula_seq_ctrl
    import ula_ctrl_pkg::*;
#(
    parameter int EXEC_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             en_a,
    output logic             en_b,
    output logic             en_res,
    output logic [1:0]       bus_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] op_cnt
);

    generate
        if ((EXEC_CYCLES < 1) || (EXEC_CYCLES > 15)) begin : g_bad_cfg
            $error("ula_seq_ctrl: EXEC_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t state;
    state_t state_nxt;
    dec_t   dec_q;
    logic   cnt_zero;

    ula_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == LOAD_B),
        .load_val (EXEC_LOAD),
        .dec      (state == EXEC),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = EXEC;
            EXEC:    if (cnt_zero) state_nxt = STORE;
            STORE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if ((state != IDLE) && abort) begin
            state_nxt = IDLE;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            dec_q  <= '0;
            op_cnt <= '0;
        end else begin
            state <= state_nxt;
            dec_q <= decode(state_nxt);
            if ((state == STORE) && !abort) begin
                op_cnt <= op_cnt + CNT_W'(1);
            end
        end
    end

    assign en_a    = dec_q.en_a   & ~abort;
    assign en_b    = dec_q.en_b   & ~abort;
    assign en_res  = dec_q.en_res & ~abort;
    assign bus_sel = dec_q.bus_sel;
    assign busy    = dec_q.busy;
    assign done    = dec_q.done;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Scoreboard bench for ula_seq_ctrl: vector table plus held-start and counter-wrap sequences.
module tb_ula_seq_ctrl;

    typedef enum logic [2:0] {T_I, T_LA, T_LB, T_E, T_ST, T_DN} tst_t;

    typedef struct {
        logic  rst;
        logic  start;
        logic  abort;
        tst_t  st;
        logic [7:0] cnt;
        string grp;
    } vec_t;

    typedef struct {
        logic        which;   // 0: EXEC_CYCLES=2 instance, 1: EXEC_CYCLES=1 instance
        logic [14:0] exp;
        string       name;
        int          idx;
    } sb_t;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic en_a2, en_b2, en_res2, busy2, done2;
    logic en_a1, en_b1, en_res1, busy1, done1;
    logic [1:0] bus_sel2, bus_sel1;
    logic [7:0] op_cnt2, op_cnt1;

    int   compared = 0;
    int   failed   = 0;
    bit   live     = 1'b0;
    sb_t  sb[$];
    sb_t  cur;
    vec_t tbl[$];
    logic [14:0] act;

    always #5 clk = ~clk;

    ula_seq_ctrl #(.EXEC_CYCLES(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .en_a(en_a2), .en_b(en_b2), .en_res(en_res2), .bus_sel(bus_sel2),
        .busy(busy2), .done(done2), .op_cnt(op_cnt2)
    );

    ula_seq_ctrl #(.EXEC_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .en_a(en_a1), .en_b(en_b1), .en_res(en_res1), .bus_sel(bus_sel1),
        .busy(busy1), .done(done1), .op_cnt(op_cnt1)
    );

    function automatic logic [14:0] expv(input tst_t t, input logic ab, input logic [7:0] c);
        logic ea, eb, er;
        logic [1:0] sel;
        ea  = (t == T_LA) && !ab;
        eb  = (t == T_LB) && !ab;
        er  = (t == T_ST) && !ab;
        sel = (t == T_I || t == T_LA) ? 2'd0 : (t == T_LB) ? 2'd1 : 2'd2;
        return {ea, eb, er, sel, (t != T_I), (t == T_DN), c};
    endfunction

    // Expected state of row i when start is held high from row 0, starting in IDLE.
    function automatic tst_t held_st(input int i, input int ex);
        int ph;
        ph = i % (ex + 5);
        if (ph == 0)           return T_I;
        else if (ph == 1)      return T_LA;
        else if (ph == 2)      return T_LB;
        else if (ph < 3 + ex)  return T_E;
        else if (ph == 3 + ex) return T_ST;
        else                   return T_DN;
    endfunction

    function automatic logic [7:0] held_cnt(input int i, input int ex);
        return 8'((i + 1) / (ex + 5));
    endfunction

    task automatic drive(input logic r, input logic s, input logic a, input bit chk,
                         input logic which, input tst_t t, input logic [7:0] c,
                         input string name, input int idx);
        sb_t e;
        @(posedge clk);
        #1;
        rst   = r;
        start = s;
        abort = a;
        live  = 1'b1;
        if (chk) begin
            e.which = which;
            e.exp   = expv(t, a, c);
            e.name  = name;
            e.idx   = idx;
            sb.push_back(e);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic a, input tst_t t,
                       input logic [7:0] c, input string g);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.st = t; v.cnt = c; v.grp = g;
        tbl.push_back(v);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            act = cur.which ? {en_a1, en_b1, en_res1, bus_sel1, busy1, done1, op_cnt1}
                            : {en_a2, en_b2, en_res2, bus_sel2, busy2, done2, op_cnt2};
            compared++;
            if (act !== cur.exp) begin
                failed++;
                $display("FAIL %s[%0d]: got {en_a,en_b,en_res,sel,busy,done,cnt}=%b_%b_%b_%b_%b_%b_%h want %b_%b_%b_%b_%b_%b_%h",
                         cur.name, cur.idx, act[14], act[13], act[12], act[11:10], act[9], act[8], act[7:0],
                         cur.exp[14], cur.exp[13], cur.exp[12], cur.exp[11:10], cur.exp[9], cur.exp[8], cur.exp[7:0]);
            end
        end
        if (live) begin
            compared++;
            if (($countones({en_a2, en_b2, en_res2}) > 1) || ($countones({en_a1, en_b1, en_res1}) > 1)) begin
                failed++;
                $display("FAIL onehot: got en2=%b en1=%b want at most one bit set",
                         {en_a2, en_b2, en_res2}, {en_a1, en_b1, en_res1});
            end
        end
    end

    initial begin
        rst = 1'b0; start = 1'b1; abort = 1'b0;

        // Reset with start held, release, single op
        add(0,1,0,T_I,0,"reset");     add(0,1,0,T_I,0,"reset");
        add(1,1,0,T_I,0,"single");    add(1,0,0,T_LA,0,"single");
        add(1,0,0,T_LB,0,"single");   add(1,0,0,T_E,0,"single");
        add(1,0,0,T_E,0,"single");    add(1,0,0,T_ST,0,"single");
        add(1,0,0,T_DN,1,"single");   add(1,0,0,T_I,1,"single");
        // Abort in EXEC
        add(1,1,0,T_I,1,"abort_exec"); add(1,0,0,T_LA,1,"abort_exec");
        add(1,0,0,T_LB,1,"abort_exec"); add(1,0,1,T_E,1,"abort_exec");
        add(1,0,0,T_I,1,"abort_exec");
        // Abort in LOAD_A masks en_a in the same cycle
        add(1,1,0,T_I,1,"abort_la");  add(1,0,1,T_LA,1,"abort_la");
        add(1,0,0,T_I,1,"abort_la");
        // Abort in STORE: no en_res, no count
        add(1,1,0,T_I,1,"abort_st");  add(1,0,0,T_LA,1,"abort_st");
        add(1,0,0,T_LB,1,"abort_st"); add(1,0,0,T_E,1,"abort_st");
        add(1,0,0,T_E,1,"abort_st");  add(1,0,1,T_ST,1,"abort_st");
        add(1,0,0,T_I,1,"abort_st");
        // start+abort in IDLE (start wins), then abort in DONE keeps done
        add(1,1,1,T_I,1,"abort_dn");  add(1,0,0,T_LA,1,"abort_dn");
        add(1,0,0,T_LB,1,"abort_dn"); add(1,0,0,T_E,1,"abort_dn");
        add(1,0,0,T_E,1,"abort_dn");  add(1,0,0,T_ST,1,"abort_dn");
        add(1,0,1,T_DN,2,"abort_dn"); add(1,0,0,T_I,2,"abort_dn");
        // start during LOAD_B ignored
        add(1,1,0,T_I,2,"start_lb");  add(1,0,0,T_LA,2,"start_lb");
        add(1,1,0,T_LB,2,"start_lb"); add(1,0,0,T_E,2,"start_lb");
        add(1,0,0,T_E,2,"start_lb");  add(1,0,0,T_ST,2,"start_lb");
        add(1,0,0,T_DN,3,"start_lb"); add(1,0,0,T_I,3,"start_lb");
        add(1,0,0,T_I,3,"start_lb");
        // Synchronous reset sampled in STORE
        add(1,1,0,T_I,3,"rst_st");    add(1,0,0,T_LA,3,"rst_st");
        add(1,0,0,T_LB,3,"rst_st");   add(1,0,0,T_E,3,"rst_st");
        add(1,0,0,T_E,3,"rst_st");    add(0,0,0,T_ST,3,"rst_st");
        add(1,0,0,T_I,0,"rst_st");    add(1,0,0,T_I,0,"rst_st");

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].abort, 1'b1, 1'b0,
                  tbl[i].st, tbl[i].cnt, tbl[i].grp, i);
        end

        // Held start on the EXEC_CYCLES=1 instance: ops at 0,6,12,18 -> op_cnt=3 at row 20
        drive(0, 0, 0, 1'b0, 1'b1, T_I, 0, "", 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 1'b1, 1'b1, held_st(i, 1), held_cnt(i, 1), "held1", i);
        end
        for (int i = 20; i < 25; i++) begin
            drive(1, 0, 0, 1'b1, 1'b1, held_st(i, 1), held_cnt(i, 1), "held1", i);
        end

        // 256 back-to-back ops on the EXEC_CYCLES=2 instance: op_cnt 255 -> 0
        drive(0, 0, 0, 1'b0, 1'b0, T_I, 0, "", 0);
        for (int i = 0; i < 256 * 7; i++) begin
            drive(1, 1, 0, 1'b1, 1'b0, held_st(i, 2), held_cnt(i, 2), "wrap", i);
        end
        drive(1, 0, 0, 1'b1, 1'b0, T_I, 8'd0, "wrap_end", 0);
        drive(1, 0, 0, 1'b1, 1'b0, T_I, 8'd0, "wrap_end", 1);

        @(posedge clk);
        @(negedge clk);
        #1;
        compared++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending entries want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/ula_seq_ctrl.md
Name: ula_seq_ctrl

Overview:
Sequencer for the ULA operand/result register bank, which consists of three 8-bit enable-loaded registers: A, B and RES.
- It shares one 8-bit source bus between the three registers by driving the bus mux select.
- It pulses each register's enable in a fixed order, then waits a configurable number of ALU cycles before capturing the result.
- It sits between the top-level start/abort control and the register bank, and counts completed operations.

Parameters:
EXEC_CYCLES, 2, number of cycles spent in EXEC waiting for ALU settling; legal range 1..15
CNT_W, 8, width of the completed-operation counter op_cnt

Ports:
clk      input   1      clock; all state changes on the rising edge
rst      input   1      reset, synchronous, active-low
start    input   1      request one operation; sampled only in IDLE
abort    input   1      cancel the operation in progress; sampled in every non-IDLE state
en_a     output  1      load enable for operand register A
en_b     output  1      load enable for operand register B
en_res   output  1      load enable for result register RES
bus_sel  output  2      source bus mux select: 0 = operand A source, 1 = operand B source, 2 = ALU result, 3 = unused
busy     output  1      high whenever state is not IDLE
done     output  1      one-cycle pulse on completion
op_cnt   output  CNT_W  count of completed operations; wraps

Behaviour:
- Reset: when rst=0 at a rising edge, the next state is IDLE, the wait counter is 0 and op_cnt is 0.
  - While in reset state, all outputs are 0: en_a, en_b, en_res, busy, done, bus_sel=0, op_cnt=0.
  - Reset mid-operation aborts with no further enables. The register bank contents are not touched.
- States: IDLE, LOAD_A, LOAD_B, EXEC, STORE, DONE.
- Outputs are decoded from the state register (Moore), except that abort gates the enables as described below.
- Transitions and outputs (cycle 0 = the edge where start is sampled high in IDLE):
  - IDLE: start=1 -> LOAD_A; otherwise stay in IDLE. bus_sel=0.
  - LOAD_A (cycle 1): en_a=1, bus_sel=0 -> LOAD_B.
  - LOAD_B (cycle 2): en_b=1, bus_sel=1 -> EXEC; the wait counter is loaded with EXEC_CYCLES-1.
  - EXEC (cycles 3 .. 2+EXEC_CYCLES): no enables, bus_sel=2. Counter decrements each cycle; counter==0 -> STORE.
  - STORE (cycle 3+EXEC_CYCLES): en_res=1, bus_sel=2 -> DONE; op_cnt increments by 1 on this edge (modulo 2^CNT_W).
  - DONE (cycle 4+EXEC_CYCLES): done=1, bus_sel=2 -> IDLE.
- busy=1 in every state except IDLE. done=1 only in DONE.
- start outside IDLE is ignored (no queuing). start held high continuously gives back-to-back operations with one IDLE cycle between them.
- Abort:
  - abort=1 in any non-IDLE state forces the next state to IDLE.
  - In the abort cycle en_a, en_b and en_res are forced to 0 combinationally (en_x = decode & ~abort).
  - op_cnt does not increment. Abort in DONE still lets the done pulse appear.
  - abort in IDLE has no effect. If abort and start are both high in IDLE, start wins.
- The wait counter is 4 bits. EXEC_CYCLES outside 1..15 is a configuration error and is flagged by an elaboration-time check.
- op_cnt wraps from 2^CNT_W-1 to 0 without any flag.
- Exactly one enable is high in any cycle, at most. The bench checks this as an invariant.

Decomposition:
- Shared package ula_ctrl_pkg holds:
  - the state encoding constants: IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, STORE=4, DONE=5, as a 3-bit type;
  - the bus_sel constants SEL_A=0, SEL_B=1, SEL_RES=2.
- One sub-module, ula_wait_cnt: a 4-bit down-counter with load, decrement and zero flag, used for the EXEC dwell. It has the same clk/rst convention as the parent.
- All other logic (next-state, output decode, op_cnt) stays in ula_seq_ctrl.

Test Plan:
- Reset: rst=0 for 2 cycles with start=1 -> all outputs 0 and op_cnt=0. After release, start=1 gives LOAD_A on the first edge.
- Single operation, EXEC_CYCLES=2: start pulse at cycle 0 -> en_a at cycle 1, en_b at 2, EXEC at 3-4 with bus_sel=2, en_res at 5, done at 6, busy at 1..6, op_cnt 0->1.
- Abort in EXEC: abort=1 at cycle 3 -> IDLE at 4, en_res never asserted, op_cnt unchanged, done never asserted.
- start held high for 20 cycles with EXEC_CYCLES=1 -> ops start at 0 and 6 and continue every 6 cycles; only in-progress ops started by edge 19 count, giving op_cnt=3 at cycle 20; at most one enable high per cycle.
- Wrap: preload by running 255 ops with CNT_W=8, then one more -> op_cnt goes 255->0. Also, start asserted during LOAD_B is ignored (no extra en_a pulse).
- Synchronous reset at STORE (rst=0 sampled at cycle 5) -> state IDLE at 6, done never asserted, op_cnt reset to 0.
